// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared load-type encodings and register constants for the writeback stage
package wb_stage_pkg;
  localparam logic [2:0] LT_W  = 3'd0;
  localparam logic [2:0] LT_B  = 3'd1;
  localparam logic [2:0] LT_BU = 3'd2;
  localparam logic [2:0] LT_H  = 3'd3;
  localparam logic [2:0] LT_HU = 3'd4;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_stage_load_ext.sv
// rtl/wb_stage_load_ext.sv - big-endian byte/halfword select and extension of raw load data
module load_ext
  import wb_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    addr_lo,
  input  logic [2:0]    load_type,
  output logic [DW-1:0] data,
  output logic          misalign
);
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Offset 0 is the most significant byte.
  always_comb begin
    sel_byte = 8'h00;
    case (addr_lo)
      2'd0: sel_byte = rdata[31:24];
      2'd1: sel_byte = rdata[23:16];
      2'd2: sel_byte = rdata[15:8];
      default: sel_byte = rdata[7:0];
    endcase
  end

  assign sel_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];

  always_comb begin
    data     = '0;
    misalign = 1'b0;
    case (load_type)
      LT_W: begin
        data     = rdata;
        misalign = (addr_lo != 2'b00);
      end
      LT_B:  data = {{(DW-8){sel_byte[7]}}, sel_byte};
      LT_BU: data = {{(DW-8){1'b0}}, sel_byte};
      LT_H: begin
        data     = {{(DW-16){sel_half[15]}}, sel_half};
        misalign = addr_lo[0];
      end
      LT_HU: begin
        data     = {{(DW-16){1'b0}}, sel_half};
        misalign = addr_lo[0];
      end
      default: misalign = 1'b1;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register, register-file write gating and retire counter
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic             mem_mem_to_reg,
  input  logic [2:0]       mem_load_type,
  input  logic [1:0]       mem_addr_lo,
  input  logic [DW-1:0]    mem_alu_result,
  input  logic [DW-1:0]    mem_rdata,
  input  logic [4:0]       mem_wreg,
  output logic             W_Enable,
  output logic [4:0]       W_Reg,
  output logic [DW-1:0]    W_data,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retired_cnt
);
  logic          wb_valid;
  logic          wb_reg_write;
  logic          wb_mem_to_reg;
  logic [2:0]    wb_load_type;
  logic [1:0]    wb_addr_lo;
  logic [DW-1:0] wb_alu_result;
  logic [DW-1:0] wb_rdata;
  logic [4:0]    wb_wreg;
  logic [DW-1:0] ld_data;
  logic          ld_misalign;

  // An instruction leaves WB when the register advances or is flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_load_type  <= 3'd0;
      wb_addr_lo    <= 2'd0;
      wb_alu_result <= '0;
      wb_rdata      <= '0;
      wb_wreg       <= 5'd0;
      retired_cnt   <= '0;
    end else begin
      if (wb_valid && (!stall || flush))
        retired_cnt <= retired_cnt + CNT_W'(1);
      if (flush) begin
        wb_valid      <= 1'b0;
        wb_reg_write  <= 1'b0;
        wb_mem_to_reg <= 1'b0;
        wb_load_type  <= 3'd0;
        wb_addr_lo    <= 2'd0;
        wb_alu_result <= '0;
        wb_rdata      <= '0;
        wb_wreg       <= 5'd0;
      end else if (!stall) begin
        wb_valid      <= mem_valid;
        wb_reg_write  <= mem_reg_write;
        wb_mem_to_reg <= mem_mem_to_reg;
        wb_load_type  <= mem_load_type;
        wb_addr_lo    <= mem_addr_lo;
        wb_alu_result <= mem_alu_result;
        wb_rdata      <= mem_rdata;
        wb_wreg       <= mem_wreg;
      end
    end
  end

  load_ext #(.DW(DW)) u_load_ext (
    .rdata     (wb_rdata),
    .addr_lo   (wb_addr_lo),
    .load_type (wb_load_type),
    .data      (ld_data),
    .misalign  (ld_misalign)
  );

  assign misalign_err = wb_valid & wb_mem_to_reg & ld_misalign;
  assign W_data       = wb_mem_to_reg ? ld_data : wb_alu_result;
  assign W_Reg        = wb_wreg;
  // The register file does not guard $0, so writes to it are dropped here.
  assign W_Enable     = wb_valid & wb_reg_write & (wb_wreg != REG_ZERO) & ~misalign_err;
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized self-checking bench for wb_stage against a behavioural model
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        mem_valid, mem_reg_write, mem_mem_to_reg;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_alu_result, mem_rdata;
  logic [4:0]  mem_wreg;
  logic        W_Enable;
  logic [4:0]  W_Reg;
  logic [31:0] W_data;
  logic        misalign_err;
  logic [31:0] retired_cnt;

  int vectors = 0;
  int errors  = 0;

  // model of the instruction currently in WB
  bit          m_valid, m_rw, m_m2r;
  int unsigned m_lt, m_alo, m_wreg;
  logic [31:0] m_alu, m_rd, m_cnt;

  wb_stage #(.DW(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_load_type(mem_load_type),
    .mem_addr_lo(mem_addr_lo), .mem_alu_result(mem_alu_result),
    .mem_rdata(mem_rdata), .mem_wreg(mem_wreg),
    .W_Enable(W_Enable), .W_Reg(W_Reg), .W_data(W_data),
    .misalign_err(misalign_err), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic exp_mis();
    if (!(m_valid && m_m2r)) return 1'b0;
    if (m_lt > 4) return 1'b1;
    if (m_lt == 0) return m_alo != 0;
    if (m_lt == 3 || m_lt == 4) return (m_alo % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_data();
    int unsigned b, h;
    if (!m_m2r) return m_alu;
    b = (m_rd >> (8 * (3 - m_alo))) & 32'hFF;
    h = (m_alo >= 2) ? (m_rd & 32'hFFFF) : (m_rd >> 16);
    case (m_lt)
      0: return m_rd;
      1: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      2: return 32'(b);
      3: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      4: return 32'(h);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_en();
    return m_valid && m_rw && (m_wreg != 0) && !exp_mis();
  endfunction

  task automatic drive(input bit v, input bit rw, input bit m2r, input int unsigned lt,
                       input int unsigned alo, input logic [31:0] alu, input logic [31:0] rd,
                       input int unsigned wr, input bit st, input bit fl);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_mem_to_reg = m2r;
    mem_load_type  = 3'(lt);
    mem_addr_lo    = 2'(alo);
    mem_alu_result = alu;
    mem_rdata      = rd;
    mem_wreg       = 5'(wr);
    stall          = st;
    flush          = fl;
  endtask

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_m2r = 0; m_lt = 0; m_alo = 0; m_wreg = 0;
    m_alu = 0; m_rd = 0;
  endtask

  // advance one clock and update the model from the inputs presented at that edge
  task automatic tick();
    @(posedge clk);
    if (m_valid && (!stall || flush)) m_cnt = m_cnt + 1;
    if (flush) model_clear();
    else if (!stall) begin
      m_valid = mem_valid; m_rw = mem_reg_write; m_m2r = mem_mem_to_reg;
      m_lt = mem_load_type; m_alo = mem_addr_lo; m_wreg = mem_wreg;
      m_alu = mem_alu_result; m_rd = mem_rdata;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 0, 0, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 7, 0, 0);
    model_clear();
    m_cnt = 0;
    #2;
    vectors++;
    if ({W_Enable, W_Reg, W_data, misalign_err} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%0b reg=%0d data=%h mis=%0b, want all 0",
               W_Enable, W_Reg, W_data, misalign_err);
    end
    vectors++;
    if (retired_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %h want 0", retired_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
  endtask

  task automatic test_alu_write();
    logic [31:0] c0;
    drive(1, 1, 0, 0, 0, 32'h1234_5678, 32'h0, 5, 0, 0);
    tick();
    c0 = m_cnt;
    vectors++;
    if (W_Enable !== 1'b1 || W_Reg !== 5'd5 || W_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_write: got en=%0b reg=%0d data=%h, want en=1 reg=5 data=12345678",
               W_Enable, W_Reg, W_data);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    vectors++;
    if (retired_cnt !== c0 + 32'd1) begin
      errors++;
      $display("FAIL alu_retire: got %h want %h", retired_cnt, c0 + 32'd1);
    end
    @(negedge clk);
  endtask

  task automatic test_loads();
    int unsigned lt[4]   = '{1, 2, 3, 4};
    int unsigned off[4]  = '{0, 3, 2, 0};
    logic [31:0] want[4] = '{32'hFFFF_FF80, 32'h0000_0001, 32'h0000_7F01, 32'h0000_80FF};
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, lt[i], off[i], 32'h0, 32'h80FF_7F01, 9, 0, 0);
      tick();
      vectors++;
      if (W_data !== want[i] || W_Enable !== 1'b1 || misalign_err !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d: got data=%h en=%0b mis=%0b, want data=%h en=1 mis=0",
                 i, W_data, W_Enable, misalign_err, want[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_faults();
    logic [31:0] c0;
    int unsigned lt[3]  = '{0, 7, 0};
    int unsigned alo[3] = '{1, 0, 0};
    bit          m2r[3] = '{1, 1, 0};
    bit          mis[3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, m2r[i], lt[i], alo[i], 32'hA5A5_0000, 32'h1111_2222, (i == 2) ? 0 : 12, 0, 0);
      tick();
      c0 = m_cnt;
      vectors++;
      if (W_Enable !== 1'b0 || misalign_err !== mis[i]) begin
        errors++;
        $display("FAIL fault_%0d: got en=%0b mis=%0b, want en=0 mis=%0b",
                 i, W_Enable, misalign_err, mis[i]);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      vectors++;
      if (retired_cnt !== c0 + 32'd1) begin
        errors++;
        $display("FAIL fault_retire_%0d: got %h want %h", i, retired_cnt, c0 + 32'd1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] c0;
    drive(1, 1, 0, 0, 0, 32'h0BAD_CAFE, 32'h0, 17, 0, 0);
    tick();
    c0 = retired_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 1, 1, $urandom_range(0, 7), $urandom_range(0, 3), $urandom, $urandom,
            $urandom_range(0, 31), 1, 0);
      tick();
      vectors++;
      if (W_Enable !== 1'b1 || W_Reg !== 5'd17 || W_data !== 32'h0BAD_CAFE || retired_cnt !== c0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got en=%0b reg=%0d data=%h cnt=%h, want en=1 reg=17 data=0badcafe cnt=%h",
                 i, W_Enable, W_Reg, W_data, retired_cnt, c0);
      end
    end
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 32'h1, 32'h0, 3, 1, 1);
    tick();
    vectors++;
    if (W_Enable !== 1'b0 || retired_cnt !== c0 + 32'd1) begin
      errors++;
      $display("FAIL stall_flush: got en=%0b cnt=%h, want en=0 cnt=%h",
               W_Enable, retired_cnt, c0 + 32'd1);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 3), $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      tick();
      vectors++;
      if (W_Enable !== exp_en() || W_Reg !== 5'(m_wreg) || misalign_err !== exp_mis() ||
          retired_cnt !== m_cnt || (!exp_mis() && W_data !== exp_data())) begin
        errors++;
        $display("FAIL random_%0d: got en=%0b reg=%0d data=%h mis=%0b cnt=%h, want en=%0b reg=%0d data=%h mis=%0b cnt=%h",
                 i, W_Enable, W_Reg, W_data, misalign_err, retired_cnt,
                 exp_en(), m_wreg, exp_data(), exp_mis(), m_cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap_reset();
    drive(1, 1, 0, 0, 0, 32'h7777_0001, 32'h0, 8, 0, 0);
    tick();
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt;
    m_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 32'h7777_0002, 32'h0, 9, 0, 0);
    tick();
    vectors++;
    if (retired_cnt !== 32'd0) begin
      errors++;
      $display("FAIL cnt_wrap: got %h want 0", retired_cnt);
    end
    vectors++;
    if (W_Enable !== 1'b1 || W_data !== 32'h7777_0002) begin
      errors++;
      $display("FAIL pre_async: got en=%0b data=%h, want en=1 data=77770002", W_Enable, W_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({W_Enable, W_Reg, W_data, misalign_err} !== 39'd0 || retired_cnt !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got en=%0b reg=%0d data=%h mis=%0b cnt=%h, want all 0",
               W_Enable, W_Reg, W_data, misalign_err, retired_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_loads();
    test_faults();
    test_stall_flush();
    test_random();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 5-stage MIPS pipeline. It sits directly upstream of the register file.
- Captures the MEM-stage result each cycle. Selects ALU result or sign/zero-extended load data.
- Drives the RF write port (W_Enable, W_Reg, W_data), which the RF samples on negedge clk.
- Suppresses writes to $0 and misaligned loads. Counts retired instructions.

Parameters:
- DW, 32, datapath width (fixed at 32 for MIPS32; other values unsupported)
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  pipeline clock; the WB register updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold the WB register contents
- flush  in  1  kill the instruction entering WB
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_reg_write  in  1  instruction writes a GPR
- mem_mem_to_reg  in  1  1 = load data, 0 = ALU result
- mem_load_type  in  3  load kind, encodings in wb_defs.vh
- mem_addr_lo  in  2  low two bits of the load address
- mem_alu_result  in  DW  ALU result / effective address
- mem_rdata  in  DW  raw word read from data memory
- mem_wreg  in  5  destination register number
- W_Enable  out  1  RF write enable
- W_Reg  out  5  RF write register number
- W_data  out  DW  RF write data
- misalign_err  out  1  WB instruction is a misaligned or illegal load
- retired_cnt  out  CNT_W  number of instructions retired

Behaviour:
- Reset (rst_n=0, async): wb_valid, all captured fields and retired_cnt are cleared to 0.
  - Consequently W_Enable=0, W_Reg=0, W_data=0, misalign_err=0.
- Posedge update, in priority order:
  - flush=1: wb_valid<=0 and wb_reg_write<=0. The data fields are don't-care and are cleared to 0.
  - else stall=1: all WB fields hold.
  - else: all mem_* inputs are captured, with mem_valid into wb_valid.
- Flush has priority over stall when both are asserted.
- Latency: one cycle from MEM inputs to the W_* outputs. W_* are combinational from the WB register only, with no path from the mem_* inputs. They are therefore stable at negedge, when the RF writes.
- Endianness is big-endian. Byte offset 0 is rdata[31:24]; offset 3 is rdata[7:0].
- Load extension (mem_to_reg=1):
  - LT_W: the whole word. Requires addr_lo=00.
  - LT_B / LT_BU: the selected byte, sign- / zero-extended to 32 bits.
  - LT_H / LT_HU: offset 0 selects [31:16], offset 2 selects [15:0]; sign- / zero-extended. Requires addr_lo[0]=0.
  - Encodings 5–7 are illegal.
- misalign_err = wb_valid & wb_mem_to_reg & (misaligned | illegal type). It is asserted for the whole time the instruction sits in WB.
- W_data = wb_mem_to_reg ? extended load : wb_alu_result.
- W_Reg = wb_wreg.
- W_Enable = wb_valid & wb_reg_write & (wb_wreg != 0) & ~misalign_err.
  - The RF does not protect $0, so this block must never assert a write to $0.
- Stall with a valid WB instruction: the same write repeats every cycle. This is idempotent and allowed.
- Retire counter: increments by 1 on posedge when wb_valid & (~stall | flush). It wraps from all-ones to 0. It counts instructions that leave WB, including ones with misalign_err and ones writing $0.
- Reset asserted mid-operation clears everything immediately. No pending write is completed.

Decomposition:
- wb_defs.vh (shared header, `include): LT_W=3'd0, LT_B=3'd1, LT_BU=3'd2, LT_H=3'd3, LT_HU=3'd4, and REG_ZERO=5'd0.
- One sub-module, load_ext: a purely combinational block taking (rdata, addr_lo, load_type) and producing (data, misalign).
- wb_stage instantiates load_ext and owns the register, write gating and counter.

Test Plan:
- Reset: hold rst_n=0 with mem_* driven valid, then release. Required: all outputs 0 before the first posedge; retired_cnt=0.
- ALU write: valid, reg_write=1, mem_to_reg=0, alu_result=0x1234_5678, wreg=5. Required: next cycle W_Enable=1, W_Reg=5, W_data=0x1234_5678; retired_cnt increments by 1.
- Loads with rdata=0x80FF_7F01:
  - LB at offset 0 gives 0xFFFF_FF80.
  - LBU at offset 3 gives 0x0000_0001.
  - LH at offset 2 gives 0x0000_7F01.
  - LHU at offset 0 gives 0x0000_80FF.
- Faults:
  - LW with addr_lo=01: W_Enable=0, misalign_err=1.
  - load_type=7: W_Enable=0, misalign_err=1.
  - ALU write to wreg=0: W_Enable=0, misalign_err=0.
  - retired_cnt still increments in all three cases.
- Stall/flush:
  - stall=1 for 3 cycles: W_* hold and retired_cnt is unchanged.
  - stall=1 and flush=1 together: next cycle W_Enable=0, and the count increments once for the departing instruction.
- Wrap and async reset: preload retired_cnt=0xFFFF_FFFF by a force, retire one instruction, and it reads 0. Then pulse rst_n low mid-cycle: outputs clear without waiting for a clock edge.
